bd_in_receiver: RTL

- Receives words from the BD chip's asynchronous 4-phase bundled-data output bus: bd_req/bd_data in, bd_ack out.
- Presents each word as a clocked valid/ack channel that feeds the BD_in input of the core, toward BD_in_FIFO and BDDecoder.
- Owns request synchronization, the handshake FSM and a one-entry output buffer, so the core stays handshake-agnostic.

---
 rtl/bd_in_receiver.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/bd_in_receiver.sv
// bd_in_receiver: bridges the BD chip's asynchronous 4-phase bundled-data
// output bus (bd_req/bd_data/bd_ack) onto a clocked valid/ack channel
// (out_v/out_d/out_a) feeding the core's BD_in path.
//
// The block synchronizes bd_req, runs the handshake FSM and holds a single
// output word. Capture and downstream drain may share an edge, so a word
// per handshake flows through with no bubble.
//
// Optional feature: define BD_IN_STALL_COUNT_EN to add a saturating 16-bit
// stall_count output. It counts edges on which BD is held off by downstream
// backpressure. Without the macro the port and the counter are absent.
//
// NSync must be at least 2.

module bd_in_receiver #(
    parameter int unsigned N     = 34,
    parameter int unsigned NSync = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         bd_req,
    input  logic [N-1:0] bd_data,
    output logic         bd_ack,
    output logic [N-1:0] out_d,
    output logic         out_v,
    input  logic         out_a
`ifdef BD_IN_STALL_COUNT_EN
    ,
    output logic [15:0]  stall_count
`endif
);

    typedef enum logic [1:0] {
        StWaitLow,
        StIdle,
        StAcked
    } state_e;

    state_e         state_q, state_d;
    logic [NSync-1:0] sync_q;
    logic           req_s;
    logic           bd_ack_q, bd_ack_d;
    logic           out_v_q, out_v_d;
    logic [N-1:0]   out_d_q, out_d_d;
    logic           xfer;
    logic           capture;
    logic           blocked;

    // The last synchronizer stage is the only view of bd_req the FSM uses.
    assign req_s = sync_q[NSync-1];

    // A transfer empties the buffer on this edge, so it may be refilled
    // on the same edge.
    assign xfer = out_v_q && out_a;

    // Synchronizer chain. It resets to all ones, so a request still high
    // across reset looks like one already seen; WAIT_LOW then drops it.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {NSync{1'b1}};
        end else begin
            sync_q <= {sync_q[NSync-2:0], bd_req};
        end
    end

    // Handshake state, acknowledge and output buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StWaitLow;
            bd_ack_q <= 1'b0;
            out_v_q  <= 1'b0;
            out_d_q  <= '0;
        end else begin
            state_q  <= state_d;
            bd_ack_q <= bd_ack_d;
            out_v_q  <= out_v_d;
            out_d_q  <= out_d_d;
        end
    end

    // Next-state logic. bd_data is read only on a capture, where the
    // synchronizer delay guarantees the bundled data has settled.
    always_comb begin
        state_d  = state_q;
        bd_ack_d = bd_ack_q;
        out_v_d  = out_v_q;
        out_d_d  = out_d_q;
        capture  = 1'b0;
        blocked  = 1'b0;

        if (xfer) begin
            out_v_d = 1'b0;
        end

        case (state_q)
            StWaitLow: begin
                bd_ack_d = 1'b0;
                if (!req_s) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                bd_ack_d = 1'b0;
                if (req_s) begin
                    if (!out_v_q || out_a) begin
                        capture  = 1'b1;
                        out_d_d  = bd_data;
                        out_v_d  = 1'b1;
                        bd_ack_d = 1'b1;
                        state_d  = StAcked;
                    end else begin
                        // Downstream is full; BD waits without an ack.
                        blocked = 1'b1;
                    end
                end
            end
            StAcked: begin
                bd_ack_d = 1'b1;
                if (!req_s) begin
                    bd_ack_d = 1'b0;
                    state_d  = StIdle;
                end
            end
            default: begin
                bd_ack_d = 1'b0;
                state_d  = StWaitLow;
            end
        endcase
    end

    assign bd_ack = bd_ack_q;
    assign out_v  = out_v_q;
    assign out_d  = out_d_q;

`ifdef BD_IN_STALL_COUNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of edges on which BD was held off by downstream.
    always_comb begin
        stall_d = stall_q;
        if (blocked && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register; cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`else
    // Without the counter the blocked and capture decodes are left unused.
    logic unused_decode;
    assign unused_decode = blocked ^ capture;
`endif

`ifdef BD_IN_STALL_COUNT_EN
    logic unused_capture;
    assign unused_capture = capture;
`endif

endmodule
